// File: rtl/aim_sweep_gen.sv
// aim_sweep_gen
//   Sweep generator for the player-aim states (angle, power). A value steps
//   between MIN and MAX once every TICK_DIV clocks, either bouncing
//   (triangle) or wrapping (sawtooth, WRAP=1). An aim-line endpoint (x,y)
//   moves in lock-step with it. A lock press freezes everything and emits a
//   one-cycle value_valid pulse for the shot FSM.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active-high
//   enable       sweep active; low returns to idle and re-arms
//   lock         player capture request, sampled every clk
//   value        current sweep value (frozen while locked)
//   value_valid  one-cycle pulse on capture
//   locked       high from capture until enable falls
//   dir          1 = counting up, 0 = counting down
//   x, y         aim-line endpoint (modular 8/7-bit arithmetic)
//   color        aim-line colour
//
// Build option
//   AIM_ENDPOINT_COLOR_EN  colour follows the sweep endpoints (111 at MAX,
//                          000 at MIN/wrap, 010 while locked). Undefined:
//                          colour is 111 whenever not idle.

module aim_sweep_gen #(
  parameter int W        = 8,
  parameter int MIN      = 0,
  parameter int MAX      = 90,
  parameter int STEP     = 5,
  parameter int TICK_DIV = 12_500_000,
  parameter int WRAP     = 0,
  parameter int X0       = 60,
  parameter int Y0       = 64,
  parameter int PIX      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         lock,
  output logic [W-1:0] value,
  output logic         value_valid,
  output logic         locked,
  output logic         dir,
  output logic [7:0]   x,
  output logic [6:0]   y,
  output logic [2:0]   color
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  MIN_V    = W'(MIN);
  localparam logic [W-1:0]  MAX_V    = W'(MAX);
  localparam logic [W-1:0]  STEP_V   = W'(STEP);
  localparam logic [7:0]    X0_V     = 8'(X0);
  localparam logic [6:0]    Y0_V     = 7'(Y0);
  localparam logic [7:0]    PIX_X    = 8'(PIX);
  localparam logic [6:0]    PIX_Y    = 7'(PIX);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  value_q, value_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic          dir_q, dir_d;
  logic          locked_q, locked_d;
  logic          valid_q, valid_d;
  logic [2:0]    color_q, color_d;

  logic          tick;
  logic [W-1:0]  val_up, val_dn;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    value_d  = value_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    color_d  = color_q;

    tick   = (presc_q == PRE_LAST);
    val_up = value_q + STEP_V;
    val_dn = value_q - STEP_V;

    if (!enable) begin
      // enable low dominates every state, including a same-cycle lock
      state_d  = IDLE;
      presc_d  = '0;
      value_d  = MIN_V;
      x_d      = X0_V;
      y_d      = Y0_V;
      dir_d    = 1'b1;
      locked_d = 1'b0;
      color_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SWEEP;
          presc_d = '0;
`ifdef AIM_ENDPOINT_COLOR_EN
          color_d = 3'b000;
`else
          color_d = 3'b111;
`endif
        end

        SWEEP: begin
          if (lock) begin
            // lock beats a coincident tick: the pre-tick value is captured
            state_d  = LOCKED;
            valid_d  = 1'b1;
            locked_d = 1'b1;
`ifdef AIM_ENDPOINT_COLOR_EN
            color_d  = 3'b010;
`endif
          end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              if (WRAP != 0) begin
                if (value_q == MAX_V) begin
                  value_d = MIN_V;
                  x_d     = X0_V;
                  y_d     = Y0_V;
`ifdef AIM_ENDPOINT_COLOR_EN
                  color_d = 3'b000;
`endif
                end else begin
                  value_d = val_up;
                  x_d     = x_q - PIX_X;
                  y_d     = y_q - PIX_Y;
`ifdef AIM_ENDPOINT_COLOR_EN
                  if (val_up == MAX_V) color_d = 3'b111;
`endif
                end
              end else if (dir_q) begin
                value_d = val_up;
                x_d     = x_q - PIX_X;
                y_d     = y_q - PIX_Y;
                if (val_up == MAX_V) begin
                  dir_d = 1'b0;
`ifdef AIM_ENDPOINT_COLOR_EN
                  color_d = 3'b111;
`endif
                end
              end else begin
                value_d = val_dn;
                x_d     = x_q + PIX_X;
                y_d     = y_q + PIX_Y;
                if (val_dn == MIN_V) begin
                  dir_d = 1'b1;
`ifdef AIM_ENDPOINT_COLOR_EN
                  color_d = 3'b000;
`endif
                end
              end
            end
          end
        end

        LOCKED: begin
          // everything held; further lock presses ignored
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      value_q  <= MIN_V;
      x_q      <= X0_V;
      y_q      <= Y0_V;
      dir_q    <= 1'b1;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      value_q  <= value_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      color_q  <= color_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign locked      = locked_q;
  assign dir         = dir_q;
  assign x           = x_q;
  assign y           = y_q;
  assign color       = color_q;

endmodule

// File: tb/tb_aim_sweep_gen.sv
module tb_aim_sweep_gen;

  typedef struct {
    int v;
    int x;
    int y;
    int d;
    int c;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en_b, lock_b, en_w, lock_w;

  logic [7:0] value_b, value_w;
  logic       valid_b, valid_w, locked_b, locked_w, dir_b, dir_w;
  logic [7:0] x_b, x_w;
  logic [6:0] y_b, y_w;
  logic [2:0] color_b, color_w;

  int n_vec = 0;
  int n_err = 0;

  exp_t chg_b[$];
  exp_t chg_w[$];
  exp_t cap_b[$];

  int prev_b = 0;
  int prev_w = 0;

  aim_sweep_gen #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(rst), .enable(en_b), .lock(lock_b),
    .value(value_b), .value_valid(valid_b), .locked(locked_b), .dir(dir_b),
    .x(x_b), .y(y_b), .color(color_b)
  );

  aim_sweep_gen #(.TICK_DIV(4), .WRAP(1)) dut_w (
    .clk(clk), .reset(rst), .enable(en_w), .lock(lock_w),
    .value(value_w), .value_valid(valid_w), .locked(locked_w), .dir(dir_w),
    .x(x_w), .y(y_w), .color(color_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t bounce_exp(input int k);
    exp_t e;
    int p;
    p   = k % 36;
    e.v = (p <= 18) ? 5 * p : 5 * (36 - p);
    e.x = 60 - e.v / 5;
    e.y = 64 - e.v / 5;
    e.d = (p < 18) ? 1 : 0;
`ifdef AIM_ENDPOINT_COLOR_EN
    e.c = (p >= 18) ? 7 : 0;
`else
    e.c = 7;
`endif
    return e;
  endfunction

  function automatic exp_t wrap_exp(input int k);
    exp_t e;
    int p;
    p   = k % 19;
    e.v = 5 * p;
    e.x = 60 - p;
    e.y = 64 - p;
    e.d = 1;
`ifdef AIM_ENDPOINT_COLOR_EN
    e.c = (p == 18) ? 7 : 0;
`else
    e.c = 7;
`endif
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.v = 0; e.x = 60; e.y = 64; e.d = 1; e.c = 0;
    return e;
  endfunction

  function automatic exp_t cap_exp(input int v);
    exp_t e;
    e.v = v; e.x = 60 - v / 5; e.y = 64 - v / 5; e.d = 1;
`ifdef AIM_ENDPOINT_COLOR_EN
    e.c = 2;
`else
    e.c = 7;
`endif
    return e;
  endfunction

  // Monitor: bounce instance. Every value change and every value_valid pulse
  // is matched against the next expectation queued by the stimulus.
  always @(negedge clk) begin
    exp_t e;
    if (int'(value_b) != prev_b) begin
      if (chg_b.size() == 0) begin
        chk("b_unexpected_change", int'(value_b), prev_b);
      end else begin
        e = chg_b.pop_front();
        chk("b_value", int'(value_b), e.v);
        chk("b_x", int'(x_b), e.x);
        chk("b_y", int'(y_b), e.y);
        chk("b_dir", int'(dir_b), e.d);
        chk("b_color", int'(color_b), e.c);
      end
      prev_b = int'(value_b);
    end
    if (valid_b) begin
      if (cap_b.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        e = cap_b.pop_front();
        chk("cap_value", int'(value_b), e.v);
        chk("cap_x", int'(x_b), e.x);
        chk("cap_y", int'(y_b), e.y);
        chk("cap_locked", int'(locked_b), 1);
        chk("cap_color", int'(color_b), e.c);
      end
    end
  end

  // Monitor: wrap instance.
  always @(negedge clk) begin
    exp_t e;
    if (int'(value_w) != prev_w) begin
      if (chg_w.size() == 0) begin
        chk("w_unexpected_change", int'(value_w), prev_w);
      end else begin
        e = chg_w.pop_front();
        chk("w_value", int'(value_w), e.v);
        chk("w_x", int'(x_w), e.x);
        chk("w_y", int'(y_w), e.y);
        chk("w_dir", int'(dir_w), e.d);
        chk("w_color", int'(color_w), e.c);
      end
      prev_w = int'(value_w);
    end
    if (valid_w) chk("w_unexpected_valid", 1, 0);
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en_b = 1'b0; lock_b = 1'b0; en_w = 1'b0; lock_w = 1'b0;
    #12;
    chk("rst_value", int'(value_b), 0);
    chk("rst_x", int'(x_b), 60);
    chk("rst_y", int'(y_b), 64);
    chk("rst_dir", int'(dir_b), 1);
    chk("rst_locked", int'(locked_b), 0);
    chk("rst_valid", int'(valid_b), 0);
    chk("rst_color", int'(color_b), 0);
    chk("rst_w_value", int'(value_w), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clk_n(2);

    // Bounce sweep: 0..90 then back down
    for (int k = 1; k <= 19; k++) chg_b.push_back(bounce_exp(k));
    en_b = 1'b1;
    clk_n(80);
    chk("t1_value_85", int'(value_b), 85);
    chk("t1_dir_down", int'(dir_b), 0);
    chg_b.push_back(idle_exp());
    en_b = 1'b0;
    clk_n(2);

    // Lock at 35, hold lock for 10 more cycles, then drop enable while locked
    for (int k = 1; k <= 7; k++) chg_b.push_back(bounce_exp(k));
    en_b = 1'b1;
    clk_n(30);
    chk("t2_pre_value", int'(value_b), 35);
    cap_b.push_back(cap_exp(35));
    lock_b = 1'b1;
    clk_n(1);
    chk("t2_valid", int'(valid_b), 1);
    clk_n(10);
    lock_b = 1'b0;
    clk_n(3);
    chk("t2_hold_value", int'(value_b), 35);
    chk("t2_hold_x", int'(x_b), 53);
    chk("t2_hold_y", int'(y_b), 57);
    chk("t2_hold_locked", int'(locked_b), 1);
    chg_b.push_back(idle_exp());
    en_b = 1'b0;
    clk_n(1);
    chk("t5_locked_clear", int'(locked_b), 0);
    chk("t5_no_valid", int'(valid_b), 0);
    clk_n(2);

    // Lock coincident with the tick that would move 20 -> 25
    for (int k = 1; k <= 4; k++) chg_b.push_back(bounce_exp(k));
    en_b = 1'b1;
    clk_n(20);
    cap_b.push_back(cap_exp(20));
    lock_b = 1'b1;
    clk_n(1);
    lock_b = 1'b0;
    clk_n(4);
    chk("t3_value", int'(value_b), 20);
    chg_b.push_back(idle_exp());
    en_b = 1'b0;
    clk_n(2);

    // Disable mid-sweep at 60 together with a lock press: no capture
    for (int k = 1; k <= 12; k++) chg_b.push_back(bounce_exp(k));
    en_b = 1'b1;
    clk_n(50);
    chk("t5_pre_value", int'(value_b), 60);
    chg_b.push_back(idle_exp());
    en_b = 1'b0;
    lock_b = 1'b1;
    clk_n(1);
    lock_b = 1'b0;
    chk("t5_mid_locked", int'(locked_b), 0);
    chk("t5_mid_dir", int'(dir_b), 1);
    chk("t5_mid_color", int'(color_b), 0);
    clk_n(3);

    // Async reset between edges at value 45, then restart with enable held
    for (int k = 1; k <= 9; k++) chg_b.push_back(bounce_exp(k));
    en_b = 1'b1;
    clk_n(38);
    chk("t6_pre_value", int'(value_b), 45);
    chg_b.push_back(idle_exp());
    #2 rst = 1'b1;
    #1;
    chk("t6_async_value", int'(value_b), 0);
    chk("t6_async_x", int'(x_b), 60);
    chk("t6_async_y", int'(y_b), 64);
    chk("t6_async_dir", int'(dir_b), 1);
    chk("t6_async_color", int'(color_b), 0);
    #3 rst = 1'b0;
    for (int k = 1; k <= 3; k++) chg_b.push_back(bounce_exp(k));
    clk_n(13);
    chk("t6_restart_value", int'(value_b), 15);
    chg_b.push_back(idle_exp());
    en_b = 1'b0;
    clk_n(2);

    // Wrap instance: 19 ticks run 0..90 then back to 0
    for (int k = 1; k <= 19; k++) chg_w.push_back(wrap_exp(k));
    en_w = 1'b1;
    clk_n(77);
    chk("t4_value", int'(value_w), 0);
    chk("t4_x", int'(x_w), 60);
    chk("t4_y", int'(y_w), 64);
    chk("t4_dir", int'(dir_w), 1);
`ifdef AIM_ENDPOINT_COLOR_EN
    chk("t4_color", int'(color_w), 0);
`else
    chk("t4_color", int'(color_w), 7);
`endif
    en_w = 1'b0;
    clk_n(2);

    chk("pending_b_changes", chg_b.size(), 0);
    chk("pending_w_changes", chg_w.size(), 0);
    chk("pending_captures", cap_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
